// File: rtl/acc_pkg.sv
// Shared ACC-core constants and the program-memory loader state encoding.
package acc_pkg;

  localparam int              ACC_AW        = 12;
  localparam int              ACC_DW        = 16;
  localparam logic [11:0]     ACC_BOOT_ADDR = 12'h800;

  // Loader states; the CHK_* states are only reached when the checksum is compiled in.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LEN_HI = 4'd1,
    ST_LEN_LO = 4'd2,
    ST_DAT_HI = 4'd3,
    ST_DAT_LO = 4'd4,
    ST_WRITE  = 4'd5,
    ST_CHK_HI = 4'd6,
    ST_CHK_LO = 4'd7,
    ST_DONE   = 4'd8
  } loader_state_e;

endpackage

// File: rtl/mem_loader.sv
// mem_loader: byte-stream program-memory writer.
// Stream: LEN_HI, LEN_LO, then N big-endian words (HI, LO), optionally followed by
// a 16-bit checksum (CHK_HI, CHK_LO) when MEM_LOADER_CHECKSUM_EN is defined.
// Each assembled word is written once through a registered single-cycle strobe,
// starting at BOOT_ADDR; the address counter wraps modulo 2^AW.
module mem_loader
  import acc_pkg::*;
#(
  parameter int              AW        = ACC_AW,
  parameter int              DW        = ACC_DW,
  parameter logic [AW-1:0]   BOOT_ADDR = AW'(ACC_BOOT_ADDR)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic          err
);

  loader_state_e state_q;
  logic          rx_ready_q;
  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] addr_q;     // next address to write
  logic [15:0]   rem_q;      // words still to be written
  logic [7:0]    len_hi_q;
  logic [7:0]    hi_q;       // high byte of the word being assembled
  logic          accept;

`ifdef MEM_LOADER_CHECKSUM_EN
  logic          err_q;
  logic [15:0]   sum_q;
  logic [7:0]    chk_hi_q;
`endif

  assign accept = rx_valid && rx_ready_q;

  // Loader FSM: all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= BOOT_ADDR;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= BOOT_ADDR;
      rem_q      <= '0;
      len_hi_q   <= '0;
      hi_q       <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
      err_q      <= 1'b0;
      sum_q      <= '0;
      chk_hi_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q    <= ST_LEN_HI;
            rx_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            addr_q     <= BOOT_ADDR;
`ifdef MEM_LOADER_CHECKSUM_EN
            err_q      <= 1'b0;
            sum_q      <= '0;
`endif
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            len_hi_q <= rx_data;
            state_q  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            rem_q <= {len_hi_q, rx_data};
            if ({len_hi_q, rx_data} == 16'd0) begin
`ifdef MEM_LOADER_CHECKSUM_EN
              state_q    <= ST_CHK_HI;
`else
              state_q    <= ST_DONE;
              rx_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
`endif
            end else begin
              state_q <= ST_DAT_HI;
            end
          end
        end
        ST_DAT_HI: begin
          if (accept) begin
            hi_q    <= rx_data;
            state_q <= ST_DAT_LO;
          end
        end
        ST_DAT_LO: begin
          if (accept) begin
            state_q    <= ST_WRITE;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b1;
            waddr_q    <= addr_q;
            wdata_q    <= {hi_q, rx_data};
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_q + {hi_q, rx_data};
`endif
          end
        end
        ST_WRITE: begin
          we_q   <= 1'b0;
          addr_q <= addr_q + 1'b1;
          rem_q  <= rem_q - 16'd1;
          if (rem_q == 16'd1) begin
`ifdef MEM_LOADER_CHECKSUM_EN
            state_q    <= ST_CHK_HI;
            rx_ready_q <= 1'b1;
`else
            state_q    <= ST_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
`endif
          end else begin
            state_q    <= ST_DAT_HI;
            rx_ready_q <= 1'b1;
          end
        end
`ifdef MEM_LOADER_CHECKSUM_EN
        ST_CHK_HI: begin
          if (accept) begin
            chk_hi_q <= rx_data;
            state_q  <= ST_CHK_LO;
          end
        end
        ST_CHK_LO: begin
          if (accept) begin
            err_q      <= ({chk_hi_q, rx_data} != sum_q);
            state_q    <= ST_DONE;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
`endif
        default: begin
          state_q    <= ST_IDLE;
          rx_ready_q <= 1'b0;
          we_q       <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready = rx_ready_q;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef MEM_LOADER_CHECKSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule
